exec_stage: RTL and testbench

- Execute stage of the 5-stage 32-bit pipeline, sitting between the decode/register-read stage and the memory stage.
- Extends the 16-bit immediate and selects the ALU B operand (BusB or extended immediate).
- Performs the ALU operation and captures the control bits, Zero flag, ALU result and store data in the EX/MEM pipeline register.

---
 rtl/exec_stage.sv | 127 ++++++++++++
 tb/tb_exec_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// ----------------------------------------------------------------------------
// exec_stage
//
// Execute stage of a 5-stage 32-bit pipeline, placed between the
// decode/register-read stage and the memory stage.
//   - Extends the immediate (sign or zero) and selects the ALU B operand.
//   - Computes the ALU result and the zero flag.
//   - Captures the control bits, zero flag, ALU result and store data in the
//     EX/MEM pipeline register.
//
// The stage has no handshake. The EX/MEM register loads on every rising
// clock edge with no enable and no stall. An asynchronous active-low reset
// clears it at once and discards whatever was in flight.
//
// Ports
//   clock, reset             : rising-edge clock, async active-low reset
//   RegDst, ALUSrc, MemToReg,
//   RegWrite, MemWr, Branch,
//   Extop, Dsize             : control inputs (Extop and ALUSrc are also
//                              used here; the rest only pass through)
//   AluCtrl                  : ALU operation select
//   Imm16, BusA, BusB        : immediate field and register operands
//   *_out                    : registered copies, 1-cycle latency
//   Zero_out, AluOut_out     : registered zero flag and ALU result
//   BusB_out                 : registered store data
// ----------------------------------------------------------------------------
module exec_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic              MemWr,
  input  logic              Branch,
  input  logic              Extop,
  input  logic [1:0]        Dsize,
  input  logic [3:0]        AluCtrl,
  input  logic [IMM_W-1:0]  Imm16,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  output logic              Extop_out,
  output logic              ALUSrc_out,
  output logic              RegDst_out,
  output logic              MemWr_out,
  output logic              Branch_out,
  output logic              MemtoReg_out,
  output logic              RegWr_out,
  output logic [1:0]        Dsize_out,
  output logic              Zero_out,
  output logic [DATA_W-1:0] AluOut_out,
  output logic [DATA_W-1:0] BusB_out
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_b;
  logic [SH_W-1:0]   w_sh;
  logic [DATA_W-1:0] w_alu;
  logic              w_zero;

  // Immediate extension: replicate the top immediate bit, or pad with zeros.
  assign w_ext = Extop ? {{(DATA_W-IMM_W){Imm16[IMM_W-1]}}, Imm16}
                       : {{(DATA_W-IMM_W){1'b0}}, Imm16};

  assign w_b  = ALUSrc ? w_ext : BusB;
  // Shifts use only the low bits of B; the upper bits are ignored.
  assign w_sh = w_b[SH_W-1:0];

  // All arithmetic wraps and ignores overflow.
  always_comb begin
    w_alu = '0;
    case (AluCtrl)
      4'b0000: w_alu = BusA + w_b;
      4'b0001: w_alu = BusA - w_b;
      4'b0010: w_alu = BusA & w_b;
      4'b0011: w_alu = BusA | w_b;
      4'b0100: w_alu = BusA ^ w_b;
      4'b0101: w_alu = ~(BusA | w_b);
      4'b0110: w_alu = BusA << w_sh;
      4'b0111: w_alu = BusA >> w_sh;
      4'b1000: w_alu = $signed(BusA) >>> w_sh;
      4'b1001: w_alu = {{(DATA_W-1){1'b0}}, ($signed(BusA) < $signed(w_b))};
      4'b1010: w_alu = {{(DATA_W-1){1'b0}}, (BusA < w_b)};
      4'b1011: w_alu = w_b << 16;
      4'b1100: w_alu = BusA;
      4'b1101: w_alu = w_b;
      default: w_alu = '0;
    endcase
  end

  assign w_zero = (w_alu == '0);

  // EX/MEM pipeline register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Extop_out    <= 1'b0;
      ALUSrc_out   <= 1'b0;
      RegDst_out   <= 1'b0;
      MemWr_out    <= 1'b0;
      Branch_out   <= 1'b0;
      MemtoReg_out <= 1'b0;
      RegWr_out    <= 1'b0;
      Dsize_out    <= 2'b00;
      Zero_out     <= 1'b0;
      AluOut_out   <= '0;
      BusB_out     <= '0;
    end else begin
      Extop_out    <= Extop;
      ALUSrc_out   <= ALUSrc;
      RegDst_out   <= RegDst;
      MemWr_out    <= MemWr;
      Branch_out   <= Branch;
      MemtoReg_out <= MemToReg;
      RegWr_out    <= RegWrite;
      Dsize_out    <= Dsize;
      Zero_out     <= w_zero;
      AluOut_out   <= w_alu;
      BusB_out     <= BusB;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// ----------------------------------------------------------------------------
// tb_exec_stage
//
// Bench for exec_stage. Each cycle the driver sets the inputs and pushes the
// expected EX/MEM contents into exp_q. One cycle later the output is popped
// and compared. The expected contents come from a reference model of the
// extender and ALU, or from fixed values for the hand-computed cases.
// Packed output layout (74 bits):
//   [73:64] {Extop, ALUSrc, RegDst, MemWr, Branch, MemtoReg, RegWr, Dsize, Zero}
//   [63:32] AluOut
//   [31:0]  BusB
// ----------------------------------------------------------------------------
module tb_exec_stage;

  localparam int OUT_W = 74;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        RegDst, ALUSrc, MemToReg, RegWrite, MemWr, Branch, Extop;
  logic [1:0]  Dsize;
  logic [3:0]  AluCtrl;
  logic [15:0] Imm16;
  logic [31:0] BusA, BusB;

  logic        Extop_out, ALUSrc_out, RegDst_out, MemWr_out, Branch_out;
  logic        MemtoReg_out, RegWr_out, Zero_out;
  logic [1:0]  Dsize_out;
  logic [31:0] AluOut_out, BusB_out;

  exec_stage #(.DATA_W(32), .IMM_W(16)) dut (
    .clock(clock), .reset(reset),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .MemWr(MemWr), .Branch(Branch), .Extop(Extop),
    .Dsize(Dsize), .AluCtrl(AluCtrl), .Imm16(Imm16),
    .BusA(BusA), .BusB(BusB),
    .Extop_out(Extop_out), .ALUSrc_out(ALUSrc_out), .RegDst_out(RegDst_out),
    .MemWr_out(MemWr_out), .Branch_out(Branch_out),
    .MemtoReg_out(MemtoReg_out), .RegWr_out(RegWr_out),
    .Dsize_out(Dsize_out), .Zero_out(Zero_out),
    .AluOut_out(AluOut_out), .BusB_out(BusB_out)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ext_model(input logic sx, input logic [15:0] imm);
    if (sx && imm[15]) return {16'hFFFF, imm};
    return {16'h0000, imm};
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + (~b) + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a & ~b;
      4'd6:  return a << s;
      4'd7:  return a >> s;
      4'd8:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd9:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      4'd11: return {b[15:0], 16'h0000};
      4'd12: return a;
      4'd13: return b;
      default: return 32'h0;
    endcase
  endfunction

  // Push the expected EX/MEM contents for the inputs currently driven.
  // When use_fix is set, fix_alu gives the expected ALU result instead of
  // the model.
  task automatic push_exp(input logic use_fix, input logic [31:0] fix_alu);
    logic [31:0] b, r;
    b = ALUSrc ? ext_model(Extop, Imm16) : BusB;
    r = use_fix ? fix_alu : alu_model(AluCtrl, BusA, b);
    exp_q.push_back({Extop, ALUSrc, RegDst, MemWr, Branch, MemToReg, RegWrite,
                     Dsize, (r == 32'h0), r, BusB});
  endtask

  function automatic logic [OUT_W-1:0] obs_vec();
    return {Extop_out, ALUSrc_out, RegDst_out, MemWr_out, Branch_out,
            MemtoReg_out, RegWr_out, Dsize_out, Zero_out, AluOut_out, BusB_out};
  endfunction

  // Advance one edge and compare the output against the oldest expectation.
  task automatic tick(input string tag);
    logic [OUT_W-1:0] e, o;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got output but nothing expected", tag);
    end else begin
      e = exp_q.pop_front();
      o = obs_vec();
      check({tag, ".flags"}, {22'h0, o[73:64]}, {22'h0, e[73:64]});
      check({tag, ".alu"},   o[63:32], e[63:32]);
      check({tag, ".busb"},  o[31:0],  e[31:0]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [OUT_W-1:0] o;
    o = obs_vec();
    check({tag, ".flags"}, {22'h0, o[73:64]}, 32'h0);
    check({tag, ".alu"},   o[63:32], 32'h0);
    check({tag, ".busb"},  o[31:0],  32'h0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ctrl(input logic [6:0] c, input logic [1:0] ds);
    {RegDst, ALUSrc, MemToReg, RegWrite, MemWr, Branch, Extop} = c;
    Dsize = ds;
  endtask

  task automatic randomize_inputs();
    set_ctrl(7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)));
    AluCtrl = 4'($urandom_range(0, 15));
    Imm16   = 16'($urandom_range(0, 65535));
    BusA    = $urandom;
    BusB    = ($urandom_range(0, 3) == 0) ? BusA : $urandom;
  endtask

  task automatic directed(input logic src, input logic sx, input logic [3:0] op,
                          input logic [15:0] imm, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_alu,
                          input string tag);
    set_ctrl({1'b0, src, 1'b0, 1'b1, 1'b0, 1'b0, sx}, 2'b10);
    AluCtrl = op; Imm16 = imm; BusA = a; BusB = b;
    push_exp(1'b1, exp_alu);
    tick(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    randomize_inputs();
    #3;
    check_all_zero("reset_init");

    @(negedge clock);
    reset = 1'b1;

    // Hand-computed cases.
    directed(1'b1, 1'b1, 4'd0,  16'hFFFF, 32'h0, 32'h5, 32'hFFFF_FFFF, "sext_add");
    directed(1'b1, 1'b0, 4'd0,  16'hFFFF, 32'h0, 32'h5, 32'h0000_FFFF, "zext_add");
    directed(1'b0, 1'b0, 4'd1,  16'h1234, 32'h1234_5678, 32'h1234_5678, 32'h0, "sub_zero");
    directed(1'b0, 1'b0, 4'd8,  16'h0, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra");
    directed(1'b0, 1'b0, 4'd7,  16'h0, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, "srl");
    directed(1'b0, 1'b0, 4'd9,  16'h0, 32'hFFFF_FFFF, 32'h1, 32'h1, "slt");
    directed(1'b0, 1'b0, 4'd10, 16'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, "sltu");
    directed(1'b0, 1'b0, 4'd0,  16'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, "add_wrap");
    directed(1'b1, 1'b0, 4'd11, 16'hABCD, 32'h0, 32'h0, 32'hABCD_0000, "lhi");
    directed(1'b0, 1'b0, 4'd14, 16'h0, 32'h1, 32'h2, 32'h0, "op_e");
    directed(1'b0, 1'b0, 4'd15, 16'h0, 32'h1, 32'h2, 32'h0, "op_f");
    directed(1'b0, 1'b0, 4'd6,  16'h0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, "sll31");

    // Every control input and Dsize toggles each cycle.
    for (int i = 0; i < 16; i++) begin
      randomize_inputs();
      set_ctrl(i[0] ? 7'h55 : 7'h2A, i[0] ? 2'b01 : 2'b10);
      push_exp(1'b0, 32'h0);
      tick("toggle");
    end

    // Model-checked random traffic.
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      push_exp(1'b0, 32'h0);
      tick("rand");
    end

    // Reset mid-stream: in-flight contents are dropped and outputs clear
    // without a clock edge.
    randomize_inputs();
    BusB = 32'hDEAD_BEEF;
    push_exp(1'b0, 32'h0);
    tick("pre_reset");
    randomize_inputs();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("reset_async");
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      @(posedge clock);
      #1;
      check_all_zero("reset_hold");
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      push_exp(1'b0, 32'h0);
      tick("post_reset");
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left in queue, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
